corelet_ctrl: RTL
=================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning MAC array rows (L0 width in vectors).
REQ-002 SHALL have parameter col, default 8, meaning MAC array columns.
REQ-003 SHALL have parameter addr_bw, default 11, meaning activation/weight memory address width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1, meaning single-cycle command strobe, sampled only in IDLE.
REQ-007 SHALL have port op, input, 1, meaning command type: 0 = LOAD_W (kernel load), 1 = EXEC (compute).
REQ-008 SHALL have port base_addr, input, addr_bw, meaning first memory address of the command, sampled with start.
REQ-009 SHALL have port len, input, addr_bw, meaning number of row-vectors to move, sampled with start.
REQ-010 SHALL have ports l0_full and l0_ready, input, 1 each, meaning L0 has at most one free entry / L0 is non-empty.
REQ-011 SHALL have ports cen_xmem and wen_xmem, output, 1 each, meaning active-low memory chip enable and write enable (inst bits 19, 18).
REQ-012 SHALL have port a_xmem, output, addr_bw, meaning memory address (inst bits 17:7).
REQ-013 SHALL have ports l0_wr and l0_rd, output, 1 each, meaning L0 write / read strobes (inst bits 2, 3).
REQ-014 SHALL have ports load and execute, output, 1 each, meaning array kernel-load / compute qualifiers.
REQ-015 SHALL have ports busy and done, output, 1 each, meaning command in progress / one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, DRAIN, FLUSH, DONE; all outputs registered.
REQ-017 SHALL, in IDLE with start=1, latch op/base_addr/len and go to FILL, or to DONE directly if len=0.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL, in FILL, issue one memory read per cycle (cen_xmem=0, wen_xmem=1, a_xmem=base_addr+k) only when l0_full=0; otherwise hold cen_xmem=1 and hold k.
REQ-020 SHALL assert l0_wr exactly one cycle after each issued read (memory read latency 1), regardless of l0_full.
REQ-021 SHALL leave FILL for DRAIN on the cycle after the last (len-th) l0_wr.
REQ-022 SHALL compute a_xmem modulo 2^addr_bw (wrap-around from all-ones to 0 is legal).
REQ-023 SHALL, in DRAIN, assert l0_rd whenever l0_ready=1, counting a vector only when l0_rd=1 and l0_ready=1, and leave for FLUSH after len counted reads.
REQ-024 SHALL assert load (op=LOAD_W) or execute (op=EXEC), never both, in the cycle following each counted L0 read.
REQ-025 SHALL remain in FLUSH for exactly row+col-1 cycles with all strobes deasserted, then enter DONE.
REQ-026 SHALL assert done for exactly one cycle in DONE and return to IDLE on the next cycle.
REQ-027 SHALL hold busy=1 in FILL, DRAIN, FLUSH and DONE and busy=0 in IDLE.
REQ-028 SHALL never assert l0_rd and l0_wr in the same cycle.

Reset
REQ-029 SHALL, while reset=0 at a clock edge, enter IDLE and drive cen_xmem=1, wen_xmem=1, a_xmem=0, l0_wr=0, l0_rd=0, load=0, execute=0, busy=0, done=0.
REQ-030 SHALL abort any in-flight command on reset with no pending l0_wr emitted afterwards.

Structure
REQ-031 SHALL take op encodings, FSM state encoding and the inst bit-position constants from shared package corelet_pkg.
REQ-032 SHALL use one sub-module, ctrl_counter (loadable up-counter with enable and terminal-count flag), for the vector and flush counters.

Verification
REQ-033 SHALL cover: reset=0 mid-FILL with len=8 -> next cycle all outputs at reset values, state IDLE, no further l0_wr.
REQ-034 SHALL cover: LOAD_W, base_addr=0x010, len=8, l0_full=0, l0_ready tied to L0 model -> a_xmem 0x010..0x017 on 8 consecutive cycles, 8 l0_wr, 8 load pulses, done 15 cycles after last load.
REQ-035 SHALL cover: EXEC, len=4, l0_full forced 1 for 3 cycles after 2nd read -> exactly 4 reads, addresses contiguous, 3-cycle cen_xmem=1 gap, 4 execute pulses, load never asserted.
REQ-036 SHALL cover: base_addr=0x7FE, len=4 -> a_xmem sequence 0x7FE, 0x7FF, 0x000, 0x001.
REQ-037 SHALL cover: len=0 -> busy for 1 cycle, done pulse, no cen_xmem/l0 strobes.
REQ-038 SHALL cover: start pulsed during DRAIN with different base_addr -> ignored, current command completes unchanged.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared encodings for the corelet controller: command ops, FSM states,
// the instruction-word field map and counter slot indices.
package corelet_pkg;

  typedef enum logic {
    OP_LOAD_W = 1'b0,
    OP_EXEC   = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bit positions of the controller fields inside the corelet inst word.
  localparam int INST_CEN   = 19;
  localparam int INST_WEN   = 18;
  localparam int INST_A_MSB = 17;
  localparam int INST_A_LSB = 7;
  localparam int INST_L0_RD = 3;
  localparam int INST_L0_WR = 2;

  // Counter slots: issued reads, moved vectors (fill then drain), flush.
  localparam int NUM_CNT = 3;
  localparam int CNT_ISS = 0;
  localparam int CNT_VEC = 1;
  localparam int CNT_FL  = 2;

  // Cycles the array needs to drain its wavefront after the last vector.
  function automatic int flush_cycles(input int r, input int c);
    return r + c - 1;
  endfunction

endpackage

// File: rtl/ctrl_counter.sv
// Loadable up-counter with enable and terminal-count compare.
module ctrl_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Load has priority over count; reset clears.
  always_ff @(posedge clk) begin
    if (!reset)   cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign tc = (cnt == lim);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet command controller: moves len row-vectors memory -> L0 (FILL),
// L0 -> MAC array (DRAIN), waits out the array pipeline (FLUSH), then
// pulses done. All outputs come straight from flops.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [addr_bw-1:0] len,
  input  logic               l0_full,
  input  logic               l0_ready,
  output logic               cen_xmem,
  output logic               wen_xmem,
  output logic [addr_bw-1:0] a_xmem,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic               load,
  output logic               execute,
  output logic               busy,
  output logic               done
);

  localparam logic [addr_bw-1:0] FLUSH_LAST = addr_bw'(flush_cycles(row, col) - 1);

  state_e             state;
  op_e                op_q;
  logic [addr_bw-1:0] base_q, len_q;

  // [0] read issued this cycle, [1] its L0 write one cycle later
  logic [1:0] vld_pipe;

  logic issue, wr_evt, rd_evt, fill_last, drain_last;

  logic [NUM_CNT-1:0]              cnt_ld, cnt_en, cnt_tc;
  logic [NUM_CNT-1:0][addr_bw-1:0] cnt_q, cnt_lim;

  assign l0_wr = vld_pipe[1];

  assign cnt_lim[CNT_ISS] = len_q;
  assign cnt_lim[CNT_VEC] = len_q - addr_bw'(1);
  assign cnt_lim[CNT_FL]  = FLUSH_LAST;

  // Per-cycle events and counter controls; counters are zeroed while idle.
  always_comb begin
    issue      = (state == ST_FILL) && !l0_full && !cnt_tc[CNT_ISS];
    wr_evt     = (state == ST_FILL) && l0_wr;
    rd_evt     = (state == ST_DRAIN) && l0_rd && l0_ready;
    fill_last  = wr_evt && cnt_tc[CNT_VEC];
    drain_last = rd_evt && cnt_tc[CNT_VEC];
    cnt_ld          = '0;
    cnt_en          = '0;
    cnt_ld[CNT_ISS] = (state == ST_IDLE);
    cnt_ld[CNT_VEC] = (state == ST_IDLE) || fill_last;
    cnt_ld[CNT_FL]  = (state == ST_IDLE);
    cnt_en[CNT_ISS] = issue;
    cnt_en[CNT_VEC] = wr_evt || rd_evt;
    cnt_en[CNT_FL]  = (state == ST_FLUSH);
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    ctrl_counter #(.W(addr_bw)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .ld     (cnt_ld[i]),
      .ld_val ('0),
      .en     (cnt_en[i]),
      .lim    (cnt_lim[i]),
      .cnt    (cnt_q[i]),
      .tc     (cnt_tc[i])
    );
  end

  // Command FSM with registered strobes; reset also flushes the read pipe
  // so no L0 write escapes after an abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_LOAD_W;
      base_q   <= '0;
      len_q    <= '0;
      vld_pipe <= '0;
      cen_xmem <= 1'b1;
      wen_xmem <= 1'b1;
      a_xmem   <= '0;
      l0_rd    <= 1'b0;
      load     <= 1'b0;
      execute  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      cen_xmem <= ~issue;
      wen_xmem <= 1'b1;
      if (issue) a_xmem <= base_q + cnt_q[CNT_ISS];
      l0_rd   <= 1'b0;
      load    <= rd_evt && (op_q == OP_LOAD_W);
      execute <= rd_evt && (op_q == OP_EXEC);
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            base_q <= base_addr;
            len_q  <= len;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (fill_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_last) state <= ST_FLUSH;
          else            l0_rd <= l0_ready;
        end
        ST_FLUSH: begin
          if (cnt_tc[CNT_FL]) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
